// File: rtl/ppu_pkg.sv
// Shared constants and helpers for the pipelined processor front end.
// Holds the NOP encoding, PC increment and IF/ID update classification.
package ppu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_action_e;

    // Flush wins over a stall: a bubble is inserted even while the PC holds.
    function automatic ifid_action_e ifidAction(input logic le, input logic flush);
        ifid_action_e action;
        action = IFID_HOLD;
        if (flush) begin
            action = IFID_BUBBLE;
        end else if (le) begin
            action = IFID_LOAD;
        end
        return action;
    endfunction

endpackage

// File: rtl/pc_npc_register.sv
// PC/nPC pair with its next-value mux; nPC supplies the branch delay slot.
// A taken branch redirects nPC only, so the slot instruction at old nPC still issues.
module pc_npc_register
    import ppu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        le,
    input  logic        branch_taken,
    input  logic [31:0] target_address,
    output logic [31:0] pc,
    output logic [31:0] npc
);

    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [31:0] w_pcNext;
    logic [31:0] w_npcNext;

    always_comb begin
        w_pcNext  = r_pc;
        w_npcNext = r_npc;
        if (le) begin
            w_pcNext = r_npc;
            if (branch_taken) begin
                w_npcNext = target_address;
            end else begin
                w_npcNext = r_npc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_npc <= RESET_PC + PC_STEP;
        end else begin
            r_pc  <= w_pcNext;
            r_npc <= w_npcNext;
        end
    end

    assign pc  = r_pc;
    assign npc = r_npc;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage plus the IF/ID pipeline register and fetch counter.
// Instruction memory is external and answers combinationally for imem_addr.
module if_id_stage
    import ppu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               le,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [31:0]        target_address,
    input  logic [31:0]        imem_data,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        pc,
    output logic [31:0]        npc,
    output logic [31:0]        instruction_id,
    output logic [31:0]        pc_id,
    output logic [31:0]        fetch_count
);

    logic [31:0]  w_pc;
    logic [31:0]  w_npc;
    ifid_action_e w_action;
    logic [31:0]  r_instructionId;
    logic [31:0]  r_pcId;
    logic [31:0]  r_fetchCount;

    pc_npc_register #(
        .RESET_PC (RESET_PC)
    ) u_pcNpc (
        .clk            (clk),
        .reset          (reset),
        .le             (le),
        .branch_taken   (branch_taken),
        .target_address (target_address),
        .pc             (w_pc),
        .npc            (w_npc)
    );

    assign w_action = ifidAction(le, flush);

    // Only real loads count as fetches; bubbles and stalls leave the counter alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instructionId <= NOP_INSTR;
            r_pcId          <= RESET_PC;
            r_fetchCount    <= 32'd0;
        end else begin
            case (w_action)
                IFID_LOAD: begin
                    r_instructionId <= imem_data;
                    r_pcId          <= w_pc;
                    r_fetchCount    <= r_fetchCount + 32'd1;
                end
                IFID_BUBBLE: begin
                    r_instructionId <= NOP_INSTR;
                    r_pcId          <= w_pc;
                end
                default: begin
                    r_instructionId <= r_instructionId;
                    r_pcId          <= r_pcId;
                end
            endcase
        end
    end

    assign imem_addr      = w_pc[IMEM_AW-1:0];
    assign pc             = w_pc;
    assign npc            = w_npc;
    assign instruction_id = r_instructionId;
    assign pc_id          = r_pcId;
    assign fetch_count    = r_fetchCount;

endmodule
